// File: rtl/usart_pkg.sv
// -----------------------------------------------------------------------------
// usart_pkg
// Shared definitions for the USART transmitter (and the later receiver):
//   - default bus addresses of TXREG / TXSTA / SPBRG
//   - TXSTA bit positions and write mask
//   - PIR1 bit driven by the transmit interrupt strobe
//   - transmitter FSM state encoding
//   - baud counter reload helper
// -----------------------------------------------------------------------------
package usart_pkg;

  localparam logic [8:0] DEF_TXREG_ADDR = 9'h019;
  localparam logic [8:0] DEF_TXSTA_ADDR = 9'h098;
  localparam logic [8:0] DEF_SPBRG_ADDR = 9'h099;

  localparam int TXSTA_CSRC = 7;
  localparam int TXSTA_TX9  = 6;
  localparam int TXSTA_TXEN = 5;
  localparam int TXSTA_SYNC = 4;
  localparam int TXSTA_BRGH = 2;
  localparam int TXSTA_TRMT = 1;
  localparam int TXSTA_TX9D = 0;

  // Bits that are actually stored on a TXSTA write; bit 3 is unimplemented
  // and TRMT is derived from the FSM.
  localparam logic [7:0] TXSTA_WMASK = 8'hF5;

  localparam int PIR1_TXIF_BIT = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_NINTH = 3'd3,
    ST_STOP  = 3'd4
  } usart_tx_state_e;

  // Counter reload for one bit: (BRGH ? 16 : 64) * (SPBRG + 1) - 1.
  // Both factors are powers of two, so the product minus one is just the
  // SPBRG value with a field of ones appended.
  function automatic logic [13:0] baud_reload(input logic [7:0] spbrg,
                                              input logic       brgh);
    if (brgh) begin
      baud_reload = {2'b00, spbrg, 4'hF};
    end else begin
      baud_reload = {spbrg, 6'h3F};
    end
  endfunction

endpackage

// File: rtl/usart_baud_gen.sv
// -----------------------------------------------------------------------------
// usart_baud_gen
// Bit-period timer shared by the USART transmitter and receiver.
// A 14-bit down-counter is loaded with BITCLKS-1 on restart and reloaded
// every time it expires, so bit_done pulses once every BITCLKS clocks while
// enabled. spbrg/brgh are sampled at every (re)load, so a rate change takes
// effect from the next bit.
// Ports:
//   clk      in   core clock
//   rst      in   synchronous active-high reset
//   spbrg    in   baud rate divisor register
//   brgh     in   high-speed select (16 vs 64 clocks per SPBRG step)
//   restart  in   load a fresh bit period on this edge
//   enable   in   count while high; bit_done is masked while low
//   bit_done out  one-cycle pulse in the last clock of each bit period
// -----------------------------------------------------------------------------
module usart_baud_gen
  import usart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] spbrg,
  input  logic       brgh,
  input  logic       restart,
  input  logic       enable,
  output logic       bit_done
);

  logic [13:0] r_cnt;
  logic [13:0] w_reload;

  assign w_reload = baud_reload(spbrg, brgh);
  assign bit_done = enable & (r_cnt == 14'd0);

  // Bit-period down-counter with reload on restart or expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 14'd0;
    end else if (restart || bit_done) begin
      r_cnt <= w_reload;
    end else if (enable) begin
      r_cnt <= r_cnt - 14'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/usart_tx_peripheral.sv
// -----------------------------------------------------------------------------
// usart_tx_peripheral
// Asynchronous serial transmitter on the core's external peripheral bus.
// Registers TXREG (transmit buffer), TXSTA (status/control) and SPBRG (baud
// divisor). Frames: start bit, 8 data bits LSB first, optional 9th bit,
// one stop bit. tx_if_strobe pulses for one cycle each time the buffer is
// handed to the shift register (TXIF in PIR1).
// Ports:
//   clk           in   core clock
//   rst           in   synchronous active-high reset
//   addr[8:0]     in   peripheral bus address
//   wr_en         in   write strobe for data_in to the addressed register
//   data_in[7:0]  in   write data
//   data_out[7:0] out  combinational read data, 8'h00 for undecoded addresses
//   tx            out  serial line, idle high
//   tx_if_strobe  out  one-cycle transmit interrupt pulse
// -----------------------------------------------------------------------------
module usart_tx_peripheral
  import usart_pkg::*;
#(
  parameter logic [8:0] TXREG_ADDR = DEF_TXREG_ADDR,
  parameter logic [8:0] TXSTA_ADDR = DEF_TXSTA_ADDR,
  parameter logic [8:0] SPBRG_ADDR = DEF_SPBRG_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] addr,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       tx,
  output logic       tx_if_strobe
);

  usart_tx_state_e r_state;
  usart_tx_state_e w_state_nxt;

  logic [7:0] r_txsta;
  logic [7:0] r_spbrg;
  logic [7:0] r_buf;
  logic       r_buf_full;
  logic [7:0] r_tsr;
  logic       r_tsr9;
  logic [2:0] r_idx;
  logic       r_tx;
  logic       r_strobe;

  logic [2:0] w_idx_nxt;
  logic       w_transfer;
  logic       w_tx_nxt;
  logic       w_run;
  logic       w_busy;
  logic       w_bit_done;
  logic       w_wr_txreg;
  logic       w_wr_txsta;
  logic       w_wr_spbrg;
  logic       w_trmt;
  logic [7:0] w_txsta_rd;

  assign w_wr_txreg = wr_en & (addr == TXREG_ADDR);
  assign w_wr_txsta = wr_en & (addr == TXSTA_ADDR);
  assign w_wr_spbrg = wr_en & (addr == SPBRG_ADDR);

  assign w_run  = r_txsta[TXSTA_TXEN] & ~r_txsta[TXSTA_SYNC];
  assign w_busy = (r_state != ST_IDLE);
  assign w_trmt = ~w_busy;

  assign w_txsta_rd = {r_txsta[7:2], w_trmt, r_txsta[0]};

  assign tx           = r_tx;
  assign tx_if_strobe = r_strobe;

  usart_baud_gen u_baud (
    .clk      (clk),
    .rst      (rst),
    .spbrg    (r_spbrg),
    .brgh     (r_txsta[TXSTA_BRGH]),
    .restart  (w_transfer),
    .enable   (w_busy),
    .bit_done (w_bit_done)
  );

  // Read mux; zero for foreign addresses so peripherals can be OR-combined.
  always_comb begin
    data_out = 8'h00;
    case (addr)
      TXREG_ADDR: data_out = r_buf;
      TXSTA_ADDR: data_out = w_txsta_rd;
      SPBRG_ADDR: data_out = r_spbrg;
      default:    data_out = 8'h00;
    endcase
  end

  // Next-state logic: frame sequencing, buffer-to-shifter transfer, abort.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_transfer  = 1'b0;
    if (!w_run) begin
      // Disabled or switched to synchronous mode: drop everything.
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_buf_full) begin
            w_transfer  = 1'b1;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_START: begin
          if (w_bit_done) begin
            w_state_nxt = ST_DATA;
            w_idx_nxt   = 3'd0;
          end else begin
            w_state_nxt = ST_START;
          end
        end
        ST_DATA: begin
          if (w_bit_done) begin
            if (r_idx == 3'd7) begin
              w_state_nxt = r_txsta[TXSTA_TX9] ? ST_NINTH : ST_STOP;
            end else begin
              w_idx_nxt = r_idx + 3'd1;
            end
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
        ST_NINTH: begin
          if (w_bit_done) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_state_nxt = ST_NINTH;
          end
        end
        ST_STOP: begin
          if (w_bit_done) begin
            if (r_buf_full) begin
              // Back-to-back frame: no idle gap after the stop bit.
              w_transfer  = 1'b1;
              w_state_nxt = ST_START;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_state_nxt = ST_STOP;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Line level for the next cycle. It follows the current state, so the
  // line lags the FSM by one clock; an abort forces it high immediately.
  always_comb begin
    w_tx_nxt = 1'b1;
    if (!w_run) begin
      w_tx_nxt = 1'b1;
    end else begin
      case (r_state)
        ST_START: w_tx_nxt = 1'b0;
        ST_DATA:  w_tx_nxt = r_tsr[r_idx];
        ST_NINTH: w_tx_nxt = r_tsr9;
        ST_STOP:  w_tx_nxt = 1'b1;
        default:  w_tx_nxt = 1'b1;
      endcase
    end
  end

  // FSM state, bit index and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= 3'd0;
      r_tx     <= 1'b1;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_tx     <= w_tx_nxt;
      r_strobe <= w_transfer;
    end
  end

  // Control registers written from the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txsta <= 8'h00;
      r_spbrg <= 8'h00;
    end else begin
      if (w_wr_txsta) begin
        r_txsta <= data_in & TXSTA_WMASK;
      end
      if (w_wr_spbrg) begin
        r_spbrg <= data_in;
      end
    end
  end

  // Transmit buffer. A write on the transfer edge wins, so the new byte
  // stays queued while the old one moves to the shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf      <= 8'h00;
      r_buf_full <= 1'b0;
    end else if (w_wr_txreg) begin
      r_buf      <= data_in;
      r_buf_full <= 1'b1;
    end else if (w_transfer || !w_run) begin
      r_buf_full <= 1'b0;
    end else begin
      r_buf_full <= r_buf_full;
    end
  end

  // Shift register and ninth bit, captured together at transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tsr  <= 8'h00;
      r_tsr9 <= 1'b0;
    end else if (w_transfer) begin
      r_tsr  <= r_buf;
      r_tsr9 <= r_txsta[TXSTA_TX9D];
    end else begin
      r_tsr  <= r_tsr;
      r_tsr9 <= r_tsr9;
    end
  end

endmodule
